// File: rtl/src2_shift_pkg.sv
// Shared types for the operand-2 shifter: mode select, shift type, Imm24 field positions.
package src2_shift_pkg;

  typedef enum logic [3:0] {
    OP_IMM   = 4'd0,
    OP_SHIMM = 4'd1,
    OP_SHREG = 4'd2
  } op_mode_e;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } sh_e;

  localparam int ROT_MSB   = 11;
  localparam int ROT_LSB   = 8;
  localparam int IMM8_MSB  = 7;
  localparam int IMM8_LSB  = 0;
  localparam int SHAMT_MSB = 11;
  localparam int SHAMT_LSB = 7;
  localparam int SH_MSB    = 6;
  localparam int SH_LSB    = 5;

endpackage

// File: rtl/src2_barrel.sv
// Combinational 32-bit shift/rotate by an 8-bit amount with register-shift carry rules.
// Amount 0 passes value and cin through unchanged.
module src2_barrel
  import src2_shift_pkg::*;
(
  input  logic [31:0] value,
  input  logic [7:0]  amount,
  input  sh_e         shtype,
  input  logic        cin,
  output logic [31:0] result,
  output logic        carry
);

  logic [31:0] lsl_r, lsr_r, asr_r, ror_r;
  logic        lsl_c, lsr_c, asr_c;
  logic [5:0]  asr_n;

  // One extra bit beside the data catches the last bit shifted out; amounts
  // past 32 naturally flush both to zero for the logical shifts.
  assign {lsl_c, lsl_r} = {1'b0, value} << amount;
  assign {lsr_r, lsr_c} = {value, 1'b0} >> amount;

  assign asr_n          = (amount > 8'd32) ? 6'd32 : amount[5:0];
  assign {asr_r, asr_c} = $signed({value, 1'b0}) >>> asr_n;

  assign ror_r = 32'({value, value} >> amount[4:0]);

  always_comb begin
    result = value;
    carry  = cin;
    if (amount != 8'd0) begin
      case (shtype)
        SH_LSL:  begin result = lsl_r; carry = lsl_c;    end
        SH_LSR:  begin result = lsr_r; carry = lsr_c;    end
        SH_ASR:  begin result = asr_r; carry = asr_c;    end
        default: begin result = ror_r; carry = ror_r[31]; end
      endcase
    end
  end

endmodule

// File: rtl/src2_shift.sv
// Operand-2 generator: rotated immediate or shifted Rm, registered with 1-cycle latency, no handshake.
// Register-specified shifts (opState=2) exist only when SRC2_SHIFT_REGSHIFT_EN is defined; otherwise pass-through.
module src2_shift
  import src2_shift_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Rs,
  input  logic [31:0] Rm,
  input  logic [23:0] Imm24,
  input  logic [3:0]  opState,
  input  logic        cin,
  output logic [31:0] src2,
  output logic        c
);

  logic [3:0]  rot4;
  logic [7:0]  imm8;
  logic [4:0]  shamt5;
  sh_e         sh;

  logic [31:0] b_val, b_res;
  logic [7:0]  b_amt;
  sh_e         b_type;
  logic        b_car;

  logic [31:0] src2_d, src2_q;
  logic        c_d, c_q;

  logic        unused_bits;
  assign unused_bits = ^{Imm24[23:12], Rs};

  assign rot4   = Imm24[ROT_MSB:ROT_LSB];
  assign imm8   = Imm24[IMM8_MSB:IMM8_LSB];
  assign shamt5 = Imm24[SHAMT_MSB:SHAMT_LSB];
  assign sh     = sh_e'(Imm24[SH_MSB:SH_LSB]);

  src2_barrel u_barrel (
    .value  (b_val),
    .amount (b_amt),
    .shtype (b_type),
    .cin    (cin),
    .result (b_res),
    .carry  (b_car)
  );

  always_comb begin
    b_val  = Rm;
    b_amt  = 8'd0;
    b_type = SH_LSL;
    src2_d = Rm;
    c_d    = cin;
    case (opState)
      OP_IMM: begin
        b_val  = {24'h0, imm8};
        b_amt  = {3'b000, rot4, 1'b0};
        b_type = SH_ROR;
        src2_d = b_res;
        c_d    = b_car;
      end
      OP_SHIMM: begin
        b_type = sh;
        // Immediate amount 0 encodes LSR/ASR #32 and RRX.
        if (shamt5 != 5'd0)
          b_amt = {3'b000, shamt5};
        else if (sh == SH_LSR || sh == SH_ASR)
          b_amt = 8'd32;
        if (shamt5 == 5'd0 && sh == SH_ROR) begin
          src2_d = {cin, Rm[31:1]};
          c_d    = Rm[0];
        end else begin
          src2_d = b_res;
          c_d    = b_car;
        end
      end
`ifdef SRC2_SHIFT_REGSHIFT_EN
      OP_SHREG: begin
        b_type = sh;
        b_amt  = Rs[7:0];
        src2_d = b_res;
        c_d    = b_car;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src2_q <= 32'h0;
      c_q    <= 1'b0;
    end else begin
      src2_q <= src2_d;
      c_q    <= c_d;
    end
  end

  assign src2 = src2_q;
  assign c    = c_q;

endmodule

// File: tb/tb_src2_shift.sv
// Randomized scoreboard bench for src2_shift against a rule-table reference model.
module tb_src2_shift;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] Rs = '0;
  logic [31:0] Rm = '0;
  logic [23:0] Imm24 = '0;
  logic [3:0]  opState = '0;
  logic        cin = 1'b0;
  logic [31:0] src2;
  logic        c;

  always #5 clk = ~clk;

  src2_shift dut (
    .clk     (clk),
    .reset   (reset),
    .Rs      (Rs),
    .Rm      (Rm),
    .Imm24   (Imm24),
    .opState (opState),
    .cin     (cin),
    .src2    (src2),
    .c       (c)
  );

  typedef struct {
    logic [31:0] r;
    logic        c;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;

  task automatic check(input string nm, input logic [31:0] ar, input logic ac,
                       input logic [31:0] er, input logic ec);
    checks++;
    if (ar !== er || ac !== ec) begin
      fails++;
      $display("FAIL %s: got src2=%h c=%b, expected src2=%h c=%b", nm, ar, ac, er, ec);
    end
  endtask

  // Shift by 1..31 as written in the rule table.
  function automatic void shift_mid(input logic [1:0] sh, input logic [31:0] rm, input int n,
                                    output logic [31:0] r, output logic co);
    case (sh)
      2'b00: begin r = rm << n; co = rm[32-n]; end
      2'b01: begin r = rm >> n; co = rm[n-1]; end
      2'b10: begin r = 32'($signed(rm) >>> n); co = rm[n-1]; end
      default: begin r = (rm >> n) | (rm << (32 - n)); co = rm[n-1]; end
    endcase
  endfunction

  function automatic void model(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rm,
                                input logic [23:0] imm, input logic ci,
                                output logic [31:0] r, output logic co);
    int          amt;
    int          n;
    logic [1:0]  sh;
    logic [31:0] i8;
    sh  = imm[6:5];
    i8  = {24'h0, imm[7:0]};
    r   = rm;
    co  = ci;
    if (op == 4'd0) begin
      amt = 2 * int'(imm[11:8]);
      r   = (amt == 0) ? i8 : ((i8 >> amt) | (i8 << (32 - amt)));
      co  = (imm[11:8] == 4'd0) ? ci : r[31];
    end else if (op == 4'd1) begin
      n = int'(imm[11:7]);
      if (n != 0) shift_mid(sh, rm, n, r, co);
      else case (sh)
        2'b00: begin r = rm; co = ci; end
        2'b01: begin r = 32'h0; co = rm[31]; end
        2'b10: begin r = {32{rm[31]}}; co = rm[31]; end
        default: begin r = {ci, rm[31:1]}; co = rm[0]; end
      endcase
`ifdef SRC2_SHIFT_REGSHIFT_EN
    end else if (op == 4'd2) begin
      n = int'(rs[7:0]);
      if (n == 0) begin
        r = rm; co = ci;
      end else if (n < 32) begin
        shift_mid(sh, rm, n, r, co);
      end else if (n == 32) begin
        case (sh)
          2'b00: begin r = 32'h0; co = rm[0]; end
          2'b01: begin r = 32'h0; co = rm[31]; end
          2'b10: begin r = {32{rm[31]}}; co = rm[31]; end
          default: begin r = rm; co = rm[31]; end
        endcase
      end else begin
        case (sh)
          2'b00, 2'b01: begin r = 32'h0; co = 1'b0; end
          2'b10: begin r = {32{rm[31]}}; co = rm[31]; end
          default: begin
            if (n % 32 == 0) begin r = rm; co = rm[31]; end
            else shift_mid(sh, rm, n % 32, r, co);
          end
        endcase
      end
`endif
    end
  endfunction

  task automatic apply(input string nm, input logic rst, input logic [31:0] rs, input logic [31:0] rm,
                       input logic [23:0] imm, input logic [3:0] op, input logic ci);
    exp_t e;
    @(negedge clk);
    reset = rst; Rs = rs; Rm = rm; Imm24 = imm; opState = op; cin = ci;
    e.name = nm;
    if (rst) begin
      e.r = 32'h0; e.c = 1'b0;
    end else begin
      model(op, rs, rm, imm, ci, e.r, e.c);
    end
    exp_q.push_back(e);
  endtask

  // Monitor: result due #1 after each edge, and must still hold after inputs move.
  initial begin
    exp_t cur;
    bit   have = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        cur  = exp_q.pop_front();
        have = 1'b1;
        check(cur.name, src2, c, cur.r, cur.c);
      end
      @(negedge clk);
      #1;
      if (have) check({cur.name, "_hold"}, src2, c, cur.r, cur.c);
    end
  end

  initial begin
    logic [31:0] rs;
    logic [3:0]  op;
    int          waited;
    apply("reset0", 1'b1, 32'h0, 32'hFFFFFFFF, 24'hFFFFFF, 4'd1, 1'b1);
    apply("reset1", 1'b1, 32'h0, 32'h12345678, 24'h000280, 4'd0, 1'b1);

    apply("lsl_imm5",   1'b0, 32'h0, 32'h00000002, 24'h000280, 4'd1, 1'b0);
    apply("rot_imm",    1'b0, 32'h0, 32'h0, 24'h000205, 4'd0, 1'b1);
    apply("rot_zero",   1'b0, 32'h0, 32'h0, 24'h0000A5, 4'd0, 1'b1);
    apply("rrx",        1'b0, 32'h0, 32'h00000003, 24'h000060, 4'd1, 1'b1);
    apply("lsr_imm0",   1'b0, 32'h0, 32'h80000000, 24'h000020, 4'd1, 1'b0);
    apply("lsl_imm0",   1'b0, 32'h0, 32'hC0FFEE01, 24'h000000, 4'd1, 1'b1);
    apply("pass_op9",   1'b0, 32'h0, 32'hDEADBEEF, 24'h000FFF, 4'd9, 1'b1);
    apply("asr_imm0",   1'b0, 32'h0, 32'h80000000, 24'h000040, 4'd1, 1'b0);
    apply("reset_mid",  1'b1, 32'h0, 32'h80000000, 24'h000040, 4'd1, 1'b0);
`ifdef SRC2_SHIFT_REGSHIFT_EN
    apply("lsr_rs32",   1'b0, 32'd32, 32'h80000000, 24'h000020, 4'd2, 1'b0);
    apply("lsr_rs40",   1'b0, 32'd40, 32'h80000000, 24'h000020, 4'd2, 1'b1);
    apply("lsl_rs32",   1'b0, 32'd32, 32'h00000001, 24'h000000, 4'd2, 1'b0);
    apply("ror_rs64",   1'b0, 32'd64, 32'h80000001, 24'h000060, 4'd2, 1'b0);
    apply("ror_rs36",   1'b0, 32'd36, 32'h0000000F, 24'h000060, 4'd2, 1'b0);
    apply("asr_rs200",  1'b0, 32'd200, 32'h80000000, 24'h000040, 4'd2, 1'b0);
    apply("rs_zero",    1'b0, 32'h100, 32'h87654321, 24'h000040, 4'd2, 1'b1);
`else
    apply("op2_pass",   1'b0, 32'd5, 32'h12345678, 24'h000020, 4'd2, 1'b1);
`endif

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: rs = $urandom_range(0, 31);
        1: rs = 32'd32;
        2: rs = $urandom_range(33, 255);
        default: rs = $urandom;
      endcase
      op = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(3, 15)) : 4'($urandom_range(0, 2));
      apply("random", ($urandom_range(0, 39) == 0), rs, $urandom, 24'($urandom), op,
            1'($urandom_range(0, 1)));
    end

    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    #3;
    checks++;
    if (exp_q.size() > 0) begin
      fails++;
      $display("FAIL drain: %0d results still pending, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
